// File: rtl/fa_pkg.sv
// -----------------------------------------------------------------------------
// fa_pkg
// Shared types for the NAND-based full adder.
//   fa_out_t    : {carry, sum} pair produced by the adder cell
//   FA_RST_VAL  : value the output register holds while reset is asserted
// -----------------------------------------------------------------------------
package fa_pkg;

  typedef struct packed {
    logic c;
    logic s;
  } fa_out_t;

  localparam fa_out_t FA_RST_VAL = '{c: 1'b0, s: 1'b0};

endpackage : fa_pkg

// File: rtl/fa_nand2.sv
// -----------------------------------------------------------------------------
// nand2
// Two-input NAND, the only gate primitive used by the adder cells.
//   x, y : gate inputs
//   z    : ~(x & y)
// -----------------------------------------------------------------------------
module nand2 (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = ~(x & y);

endmodule : nand2

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa
// Single-bit full adder built from nine 2-input NANDs, with a registered copy
// of its outputs for clocked consumers.
//   clk   : rising-edge clock for the output register
//   rst_n : asynchronous active-low reset (clears s_q/c_q only)
//   a, b  : addend bits
//   cin   : carry-in bit
//   s, c  : combinational sum / carry-out, valid regardless of clk and rst_n
//   s_q   : s registered on clk
//   c_q   : c registered on clk
// -----------------------------------------------------------------------------
module fa
  import fa_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c,
  output logic s_q,
  output logic c_q
);

  logic t1, t2, t3, p, t4, t5, t6;

  // First half: p = a ^ b, with t1 = ~(a & b) reused by the carry gate.
  nand2 u_t1 (.x(a),   .y(b),   .z(t1));
  nand2 u_t2 (.x(a),   .y(t1),  .z(t2));
  nand2 u_t3 (.x(b),   .y(t1),  .z(t3));
  nand2 u_p  (.x(t2),  .y(t3),  .z(p));

  // Second half: s = p ^ cin, with t4 = ~(p & cin) shared by the carry gate.
  nand2 u_t4 (.x(p),   .y(cin), .z(t4));
  nand2 u_t5 (.x(p),   .y(t4),  .z(t5));
  nand2 u_t6 (.x(cin), .y(t4),  .z(t6));
  nand2 u_s  (.x(t5),  .y(t6),  .z(s));

  // Carry: c = (a & b) | (p & cin), expressed as NAND of the two inverted terms.
  nand2 u_c  (.x(t1),  .y(t4),  .z(c));

  fa_out_t res_d;
  fa_out_t res_q;

  // Next-state for the output register is simply the current adder result.
  always_comb begin
    res_d   = FA_RST_VAL;
    res_d.s = s;
    res_d.c = c;
  end

  // Output register; reset clears it immediately without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= FA_RST_VAL;
    end else begin
      res_q <= res_d;
    end
  end

  assign s_q = res_q.s;
  assign c_q = res_q.c;

endmodule : fa

// File: tb/tb_fa.sv
// -----------------------------------------------------------------------------
// tb_fa
// Self-checking bench for the NAND full adder: truth-table vectors, hand-written
// reset/latency/toggling sequences, and randomized stimulus against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fa;

  logic clk;
  logic rst_n;
  logic a, b, cin;
  logic s, c, s_q, c_q;

  int n_total;
  int n_pass;

  typedef struct {
    logic [2:0] abc;
    logic [1:0] cs;
  } vec_t;

  vec_t vecs [8];

  fa dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .c     (c),
    .s_q   (s_q),
    .c_q   (c_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got c,s=%b required c,s=%b at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [2:0] abc);
    a   = abc[2];
    b   = abc[1];
    cin = abc[0];
  endtask

  // Reference model: {c,s} is the 2-bit unsigned sum of the three input bits.
  function automatic logic [1:0] model(input logic [2:0] abc);
    int sum;
    sum = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
    return 2'(sum);
  endfunction

  initial begin
    logic [2:0] r;
    logic [1:0] exp_reg;
    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{3'b000, 2'b00};
    vecs[1] = '{3'b001, 2'b01};
    vecs[2] = '{3'b010, 2'b01};
    vecs[3] = '{3'b011, 2'b10};
    vecs[4] = '{3'b100, 2'b01};
    vecs[5] = '{3'b101, 2'b10};
    vecs[6] = '{3'b110, 2'b10};
    vecs[7] = '{3'b111, 2'b11};

    // Combinational outputs valid during reset; register held at zero.
    rst_n = 1'b0;
    drive(3'b101);
    #1;
    check("reset_comb", {c, s}, 2'b10);
    check("reset_reg", {c_q, s_q}, 2'b00);
    @(posedge clk); #1;
    check("reset_reg_after_edge", {c_q, s_q}, 2'b00);

    // Release reset away from an edge, then sweep the truth table.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].abc);
      #1;
      check($sformatf("table_comb_%03b", vecs[i].abc), {c, s}, vecs[i].cs);
      @(posedge clk); #1;
      check($sformatf("table_reg_%03b", vecs[i].abc), {c_q, s_q}, vecs[i].cs);
    end

    // Register latency: new inputs visible on s_q/c_q only after the edge.
    @(negedge clk);
    drive(3'b110);
    #1;
    check("latency_before_edge", {c_q, s_q}, 2'b11);
    @(posedge clk); #1;
    check("latency_after_edge", {c_q, s_q}, 2'b10);

    // Async reset mid-cycle clears the register with no clock edge.
    @(negedge clk);
    drive(3'b111);
    @(posedge clk); #1;
    check("async_pre", {c_q, s_q}, 2'b11);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(3'b111);
    #1;
    check("async_cleared", {c_q, s_q}, 2'b00);
    check("async_comb_live", {c, s}, 2'b11);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("async_reload", {c_q, s_q}, 2'b11);

    // Input toggling between edges: only the value at the edge is captured.
    @(negedge clk);
    drive(3'b001);
    #1;
    check("toggle_comb_001", {c, s}, 2'b01);
    #2;
    drive(3'b110);
    #1;
    check("toggle_comb_110", {c, s}, 2'b10);
    @(posedge clk); #1;
    check("toggle_reg", {c_q, s_q}, 2'b10);

    // Randomized stimulus with occasional mid-cycle reset pulses.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = 3'($urandom_range(7, 0));
      drive(r);
      #1;
      check("rand_comb", {c, s}, model(r));
      if ($urandom_range(15, 0) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async_reset", {c_q, s_q}, 2'b00);
        rst_n = 1'b1;
      end
      exp_reg = model(r);
      @(posedge clk); #1;
      check("rand_reg", {c_q, s_q}, exp_reg);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fa
